spmv_resp_drain: RTL and testbench
==================================

# spmv_resp_drain

Result-drain stage directly downstream of the SpMV output vector buffer inside the tight accelerator interface. Once computation reaches SPMV_FINISHED it reads the computed rows out of the output buffer, packs two elements per 64-bit word, and returns them to the core over the `resp_val`/`resp_rdy`/`resp_data` channel. It drives `output_empty` back to the command state machine to signal that the drain is complete.

## Interface
- `DATA_W`, 32: output element width; legal range 1..32; each element is zero-extended to 32 bits in its response half.
- `DIM_W`, 10: row-index width; the buffer depth is 2^DIM_W.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle pulse when the top enters SPMV_FINISHED; honoured only in IDLE.
- `abort`  in  1  synchronous clear, driven by `spmv_init`; returns the block to IDLE from any state.
- `num_rows`  in  DIM_W  number of rows to drain (`spm_nr`); sampled on an accepted `start`.
- `buf_rd_en`  out  1  output-buffer read strobe.
- `buf_rd_addr`  out  DIM_W  row index to read.
- `buf_rd_data`  in  DATA_W  buffer data; valid exactly one cycle after `buf_rd_en`.
- `resp_val`  out  1  a response word is valid.
- `resp_rdy`  in  1  core accepts the word.
- `resp_data`  out  64  bits [31:0] hold row 2k; bits [63:32] hold row 2k+1.
- `output_empty`  out  1  high when nothing remains to drain.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, RD_LO, RD_HI, CAP and SEND.
- IDLE:
  - On `start` with `num_rows`≠0: latch `num_rows` into `rows_q`, clear `idx` to 0, go to RD_LO.
  - On `start` with `num_rows`=0: stay in IDLE with no response.
- RD_LO: assert `buf_rd_en` with `buf_rd_addr`=`idx`; go to RD_HI.
- RD_HI:
  - Latch `buf_rd_data` into `lo_q`.
  - If `idx+1` < `rows_q`, assert `buf_rd_en` with address `idx+1`.
  - Otherwise issue no read and set a zero-pad flag.
  - Go to CAP.
- CAP: latch `buf_rd_data` into `hi_q`, or load 0 if the zero-pad flag is set; go to SEND.
- SEND:
  - `resp_val`=1 and `resp_data`={`hi_q`,`lo_q`}, each half zero-extended.
  - On `resp_val`&`resp_rdy`: `idx` += 2. Compute `idx` at DIM_W+1 bits so that 1023+2 does not wrap.
  - If the new `idx` ≥ `rows_q`, go to IDLE; otherwise go to RD_LO.
- `output_empty` = (state==IDLE). `busy` = !`output_empty`.
- `start` outside IDLE is ignored; `num_rows` is not resampled.
- `abort` or `rst` forces IDLE and clears `idx`, `lo_q`, `hi_q`, the zero-pad flag and `rows_q`.
- `abort` takes priority over `start` and over a `resp_rdy` in the same cycle. A word being handshaken in that cycle is treated as not delivered.
- Rows are drained strictly in ascending index order; no row is read twice.

## Timing
- Reset values: `resp_val`=0, `resp_data`=0, `buf_rd_en`=0, `buf_rd_addr`=0, `output_empty`=1, `busy`=0.
- `start` accepted at edge T:
  - `buf_rd_en` is high during cycle T+1 (RD_LO).
  - The second read is issued in T+2.
  - `resp_val` first rises in cycle T+4.
- Each word occupies at least 4 cycles (RD_LO→RD_HI→CAP→SEND). Back-pressure extends SEND indefinitely.
- While `resp_val`=1 and `resp_rdy`=0, `resp_data` is held stable. `resp_val` does not drop without a handshake, except on `abort` or `rst`.
- After the final handshake, `output_empty` rises in the next cycle.
- `buf_rd_en` is high only in RD_LO, and in RD_HI when the pair is not padded.
- Outputs are registered or decoded from the state register only; `resp_val` has no combinational path from `resp_rdy`.

## Test plan
- Reset, then `num_rows`=4 with buffer[i]=0x100+i and `resp_rdy`=1 → two words, 0x00000101_00000100 then 0x00000103_00000102. The first `resp_val` is at start+4. `output_empty` rises one cycle after the second handshake.
- `num_rows`=3 → second word is 0x00000000_00000102. Exactly 3 `buf_rd_en` pulses, at addresses 0, 1 and 2.
- `num_rows`=2 with `resp_rdy` held low for 10 cycles → `resp_val` and `resp_data` stay constant for 10 cycles. Exactly one word is delivered after `resp_rdy` rises.
- `num_rows`=0 → no `buf_rd_en`, no `resp_val`; `output_empty` stays 1.
- `abort` pulse while in SEND with `resp_rdy`=1, `num_rows`=6 → the next cycle is IDLE with `resp_val`=0 and `output_empty`=1. A fresh `start` with `num_rows`=2 restarts at address 0.
- `num_rows`=1023 (maximum) with random `resp_rdy` → 512 words delivered, the last with its upper half zero. There is no index wrap, and a `start` pulse issued mid-drain is ignored.

Source files
------------

// File: rtl/spmv_resp_drain.sv
// Result-drain stage: reads computed rows from the SpMV output buffer, packs two
// rows per 64-bit response word and returns them over a valid/ready channel.
module spmv_resp_drain #(
   parameter int DATA_W = 32,
   parameter int DIM_W  = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DIM_W-1:0]  num_rows_i,
   output logic              buf_rd_en_o,
   output logic [DIM_W-1:0]  buf_rd_addr_o,
   input  logic [DATA_W-1:0] buf_rd_data_i,
   output logic              resp_val_o,
   input  logic              resp_rdy_i,
   output logic [63:0]       resp_data_o,
   output logic              output_empty_o,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      CAP,
      SEND
   } state_e;

   localparam logic [DIM_W:0] IDX_ONE = (DIM_W+1)'(1);
   localparam logic [DIM_W:0] IDX_TWO = (DIM_W+1)'(2);

   state_e              state_q, state_d;
   logic [DIM_W-1:0]    rows_q, rows_d;
   logic [DIM_W:0]      idx_q, idx_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic                pad_q, pad_d;

   // The index is one bit wider than a row address so idx+2 past the last row cannot wrap.
   logic [DIM_W:0]      rows_ext;
   logic [DIM_W:0]      idx_inc1;
   logic [DIM_W:0]      idx_inc2;
   logic                have_hi;
   logic [31:0]         lo_ext;
   logic [31:0]         hi_ext;

   assign rows_ext = {1'b0, rows_q};
   assign idx_inc1 = idx_q + IDX_ONE;
   assign idx_inc2 = idx_q + IDX_TWO;
   assign have_hi  = (idx_inc1 < rows_ext);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rows_q  <= '0;
         idx_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         pad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         pad_q   <= pad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      pad_d   = pad_q;
      case (state_q)
         IDLE: begin
            if (start_i && (num_rows_i != '0)) begin
               rows_d  = num_rows_i;
               idx_d   = '0;
               state_d = RD_LO;
            end
         end
         RD_LO: begin
            state_d = RD_HI;
         end
         RD_HI: begin
            lo_d    = buf_rd_data_i;
            pad_d   = !have_hi;
            state_d = CAP;
         end
         CAP: begin
            hi_d    = pad_q ? '0 : buf_rd_data_i;
            state_d = SEND;
         end
         SEND: begin
            if (resp_rdy_i) begin
               idx_d   = idx_inc2;
               state_d = (idx_inc2 >= rows_ext) ? IDLE : RD_LO;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Abort wins over start and over a same-cycle handshake: that word counts as undelivered.
      if (abort_i) begin
         state_d = IDLE;
         rows_d  = '0;
         idx_d   = '0;
         lo_d    = '0;
         hi_d    = '0;
         pad_d   = 1'b0;
      end
   end

   always_comb begin
      lo_ext             = '0;
      hi_ext             = '0;
      lo_ext[DATA_W-1:0] = lo_q;
      hi_ext[DATA_W-1:0] = hi_q;
   end

   always_comb begin
      buf_rd_en_o   = 1'b0;
      buf_rd_addr_o = '0;
      resp_val_o    = 1'b0;
      resp_data_o   = '0;
      case (state_q)
         RD_LO: begin
            buf_rd_en_o   = 1'b1;
            buf_rd_addr_o = idx_q[DIM_W-1:0];
         end
         RD_HI: begin
            if (have_hi) begin
               buf_rd_en_o   = 1'b1;
               buf_rd_addr_o = idx_inc1[DIM_W-1:0];
            end
         end
         SEND: begin
            resp_val_o  = 1'b1;
            resp_data_o = {hi_ext, lo_ext};
         end
         default: begin
            buf_rd_en_o = 1'b0;
         end
      endcase
   end

   assign output_empty_o = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_spmv_resp_drain.sv
// Scoreboard bench for spmv_resp_drain: directed drains with an output-buffer model
// and a monitor that checks response words and read-address ordering.
module tb_spmv_resp_drain;

   localparam int DATA_W = 32;
   localparam int DIM_W  = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [DIM_W-1:0]  num_rows;
   logic              buf_rd_en;
   logic [DIM_W-1:0]  buf_rd_addr;
   logic [DATA_W-1:0] buf_rd_data;
   logic              resp_val;
   logic              resp_rdy;
   logic [63:0]       resp_data;
   logic              output_empty;
   logic              busy;

   logic [31:0] mem [0:1023];
   logic [63:0] sbQ [$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int delivered = 0;
   int rdCount = 0;
   int rdExpAddr = 0;
   int lastHsCycle = 0;
   bit valSeen = 1'b0;
   bit emptyDropped = 1'b0;
   bit holdPrev = 1'b0;
   logic [63:0] holdData = '0;

   always #5 clk = ~clk;

   spmv_resp_drain #(
      .DATA_W(DATA_W),
      .DIM_W (DIM_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .abort_i       (abort),
      .num_rows_i    (num_rows),
      .buf_rd_en_o   (buf_rd_en),
      .buf_rd_addr_o (buf_rd_addr),
      .buf_rd_data_i (buf_rd_data),
      .resp_val_o    (resp_val),
      .resp_rdy_i    (resp_rdy),
      .resp_data_o   (resp_data),
      .output_empty_o(output_empty),
      .busy_o        (busy)
   );

   // Output buffer: data appears exactly one cycle after the read strobe.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
      buf_rd_data = '0;
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
   end

   // Monitor: word compare on handshake, ascending read order, and hold stability under back-pressure.
   always @(negedge clk) begin
      logic [63:0] exp;
      if (!rst) begin
         if (holdPrev) begin
            checks++;
            if (!(resp_val === 1'b1 && resp_data === holdData)) begin
               errors++;
               $display("[TB] FAIL hold_stable: got val=%0b data=%h, required val=1 data=%h",
                        resp_val, resp_data, holdData);
            end
         end
         if (buf_rd_en) begin
            rdCount++;
            checks++;
            if (int'(buf_rd_addr) != rdExpAddr) begin
               errors++;
               $display("[TB] FAIL rd_addr: got %0d, required %0d", buf_rd_addr, rdExpAddr);
            end
            rdExpAddr++;
         end
         if (resp_val) valSeen = 1'b1;
         if (!output_empty) emptyDropped = 1'b1;
         if (resp_val && resp_rdy && !abort) begin
            delivered++;
            lastHsCycle = cyc;
            checks++;
            if (sbQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_word: got %h, required no word", resp_data);
            end else begin
               exp = sbQ.pop_front();
               if (resp_data !== exp) begin
                  errors++;
                  $display("[TB] FAIL resp_word: got %h, required %h", resp_data, exp);
               end
            end
         end
      end
      holdPrev = resp_val && !resp_rdy && !abort && !rst;
      holdData = resp_data;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // Pulses start for one cycle; returns one cycle after the accepting edge.
   task automatic applyStimulus(input int rows);
      num_rows     = DIM_W'(rows);
      rdExpAddr    = 0;
      rdCount      = 0;
      delivered    = 0;
      valSeen      = 1'b0;
      emptyDropped = 1'b0;
      start        = 1'b1;
      step();
      start        = 1'b0;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n = 0;
      while (!output_empty && n < maxCycles) begin
         step();
         n++;
      end
      checkOutput("drain_done", 64'(n < maxCycles), 64'd1);
   endtask

   task automatic waitVal(input int maxCycles, output int n);
      n = 0;
      while (!resp_val && n < maxCycles) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      logic [63:0] held;
      logic [31:0] lo;
      logic [31:0] hi;

      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      num_rows = '0;
      resp_rdy = 1'b0;
      repeat (3) step();
      checkOutput("rst_resp_val", 64'(resp_val), 64'd0);
      checkOutput("rst_resp_data", resp_data, 64'd0);
      checkOutput("rst_rd_en", 64'(buf_rd_en), 64'd0);
      checkOutput("rst_rd_addr", 64'(buf_rd_addr), 64'd0);
      checkOutput("rst_empty", 64'(output_empty), 64'd1);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();

      // Four rows, always ready.
      resp_rdy = 1'b1;
      sbQ.push_back(64'h00000101_00000100);
      sbQ.push_back(64'h00000103_00000102);
      applyStimulus(4);
      checkOutput("t1_first_rd_en", 64'(buf_rd_en), 64'd1);
      waitVal(20, n);
      checkOutput("t1_first_val_latency", 64'(n), 64'd3);
      waitDrain(50);
      checkOutput("t1_empty_after_last_hs", 64'(cyc - lastHsCycle), 64'd1);
      checkOutput("t1_delivered", 64'(delivered), 64'd2);
      checkOutput("t1_queue_left", 64'(sbQ.size()), 64'd0);
      step();

      // Odd row count: upper half of the last word is padded with zero.
      sbQ.push_back(64'h00000101_00000100);
      sbQ.push_back(64'h00000000_00000102);
      applyStimulus(3);
      waitDrain(50);
      checkOutput("t2_rd_pulses", 64'(rdCount), 64'd3);
      checkOutput("t2_delivered", 64'(delivered), 64'd2);
      checkOutput("t2_queue_left", 64'(sbQ.size()), 64'd0);
      step();

      // Back-pressure for ten cycles.
      resp_rdy = 1'b0;
      sbQ.push_back(64'h00000101_00000100);
      applyStimulus(2);
      waitVal(20, n);
      held = resp_data;
      repeat (10) step();
      checkOutput("t3_val_held", 64'(resp_val), 64'd1);
      checkOutput("t3_data_held", resp_data, held);
      checkOutput("t3_none_before_rdy", 64'(delivered), 64'd0);
      resp_rdy = 1'b1;
      waitDrain(20);
      checkOutput("t3_delivered", 64'(delivered), 64'd1);
      step();

      // Zero rows: nothing happens.
      applyStimulus(0);
      repeat (8) step();
      checkOutput("t4_rd_pulses", 64'(rdCount), 64'd0);
      checkOutput("t4_val_seen", 64'(valSeen), 64'd0);
      checkOutput("t4_empty_dropped", 64'(emptyDropped), 64'd0);

      // Abort during SEND with ready high, then a fresh restart.
      resp_rdy = 1'b1;
      applyStimulus(6);
      waitVal(20, n);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("t5_val_after_abort", 64'(resp_val), 64'd0);
      checkOutput("t5_empty_after_abort", 64'(output_empty), 64'd1);
      checkOutput("t5_busy_after_abort", 64'(busy), 64'd0);
      checkOutput("t5_aborted_delivered", 64'(delivered), 64'd0);
      sbQ.push_back(64'h00000101_00000100);
      applyStimulus(2);
      waitDrain(30);
      checkOutput("t5_restart_rd_pulses", 64'(rdCount), 64'd2);
      checkOutput("t5_restart_delivered", 64'(delivered), 64'd1);
      step();

      // Maximum row count, random ready, ignored mid-drain start.
      for (int k = 0; k < 512; k++) begin
         lo = 32'h100 + 32'(2 * k);
         hi = (2 * k + 1 < 1023) ? 32'h100 + 32'(2 * k + 1) : 32'h0;
         sbQ.push_back({hi, lo});
      end
      resp_rdy = 1'b0;
      applyStimulus(1023);
      n = 0;
      while (!output_empty && n < 20000) begin
         step();
         n++;
         resp_rdy = 1'($urandom_range(0, 1));
         if (n == 300) begin
            start    = 1'b1;
            num_rows = DIM_W'(5);
         end else if (n == 301) begin
            start = 1'b0;
         end
      end
      checkOutput("t6_drain_done", 64'(n < 20000), 64'd1);
      checkOutput("t6_rd_pulses", 64'(rdCount), 64'd1023);
      checkOutput("t6_delivered", 64'(delivered), 64'd512);
      checkOutput("t6_queue_left", 64'(sbQ.size()), 64'd0);
      repeat (6) step();
      checkOutput("t6_stays_idle", 64'(output_empty), 64'd1);
      checkOutput("t6_no_extra_words", 64'(delivered), 64'd512);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
